// File: rtl/cw_responder_pkg.sv
// Shared CW bus constants: word widths, header bit positions and FSM state encoding.
package cw_responder_pkg;

    localparam int unsigned RW        = 16;
    localparam int unsigned WbAddrW   = 24;
    // Header word bit positions
    localparam int unsigned HdrWe     = 15;
    localparam int unsigned HdrBurst4 = 14;
    localparam int unsigned HdrBurst8 = 13;
    localparam int unsigned HdrSelHi  = 12;
    localparam int unsigned HdrSelLo  = 11;
    // Header carries the address bits above the 16 supplied by frame word 1
    localparam int unsigned HdrAdrW   = WbAddrW - RW;

    typedef enum logic [2:0] {
        StIdle,
        StAdr,
        StWaitW,
        StWb,
        StResp
    } state_e;

    // Index of the final beat of a frame: 0, 3 or 7
    function automatic logic [2:0] last_beat_idx(input logic burst4, input logic burst8);
        if (burst8) begin
            return 3'd7;
        end else if (burst4) begin
            return 3'd3;
        end
        return 3'd0;
    endfunction

endpackage

// File: rtl/cw_responder.sv
// CW bus responder: decodes a two-word header, then runs 1/4/8 wishbone beats,
// returning one cw_ack (or a terminating cw_err) per beat.
module cw_responder
    import cw_responder_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [RW-1:0]      cw_io_i,
    output logic [RW-1:0]      cw_io_o,
    output logic               cw_io_oe,
    input  logic               cw_req,
    input  logic               cw_dir,
    output logic               cw_ack,
    output logic               cw_err,
    output logic               wb_cyc,
    output logic               wb_stb,
    output logic               wb_we,
    output logic [WbAddrW-1:0] wb_adr,
    output logic [RW-1:0]      wb_o_dat,
    input  logic [RW-1:0]      wb_i_dat,
    output logic [1:0]         wb_sel,
    input  logic               wb_ack,
    input  logic               wb_err
);

    localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

    state_e               state_q;
    logic [2:0]           beat_q;
    logic [2:0]           last_q;
    logic                 bad_q;
    logic [HdrAdrW-1:0]   adr_hi_q;
    logic [CntW-1:0]      cnt_q;
    logic [RW-1:0]        rdata_q;
    logic                 wb_cyc_q;
    logic                 wb_stb_q;
    logic                 wb_we_q;
    logic [WbAddrW-1:0]   wb_adr_q;
    logic [RW-1:0]        wb_o_dat_q;
    logic [1:0]           wb_sel_q;
    logic                 cw_ack_q;
    logic                 cw_err_q;
    logic                 timeout;

    assign timeout  = (cnt_q == TimeoutCnt);

    assign cw_io_oe = cw_dir & (state_q != StIdle);
    assign cw_io_o  = cw_io_oe ? rdata_q : '0;
    assign cw_ack   = cw_ack_q;
    assign cw_err   = cw_err_q;
    assign wb_cyc   = wb_cyc_q;
    assign wb_stb   = wb_stb_q;
    assign wb_we    = wb_we_q;
    assign wb_adr   = wb_adr_q;
    assign wb_o_dat = wb_o_dat_q;
    assign wb_sel   = wb_sel_q;

    // Frame FSM with all bus outputs registered; cw_ack/cw_err are single-cycle pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            beat_q     <= '0;
            last_q     <= '0;
            bad_q      <= 1'b0;
            adr_hi_q   <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            wb_cyc_q   <= 1'b0;
            wb_stb_q   <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_adr_q   <= '0;
            wb_o_dat_q <= '0;
            wb_sel_q   <= '0;
            cw_ack_q   <= 1'b0;
            cw_err_q   <= 1'b0;
        end else begin
            cw_ack_q <= 1'b0;
            cw_err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cw_req) begin
                        wb_we_q  <= cw_io_i[HdrWe];
                        wb_sel_q <= cw_io_i[HdrSelHi:HdrSelLo];
                        adr_hi_q <= cw_io_i[HdrAdrW-1:0];
                        bad_q    <= cw_io_i[HdrBurst4] & cw_io_i[HdrBurst8];
                        last_q   <= last_beat_idx(cw_io_i[HdrBurst4], cw_io_i[HdrBurst8]);
                        state_q  <= StAdr;
                    end
                end
                StAdr: begin
                    wb_adr_q <= {adr_hi_q, cw_io_i};
                    beat_q   <= '0;
                    if (bad_q) begin
                        cw_err_q <= 1'b1;
                        state_q  <= StIdle;
                    end else if (wb_we_q) begin
                        state_q <= StWaitW;
                    end else begin
                        wb_cyc_q <= 1'b1;
                        wb_stb_q <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= StWb;
                    end
                end
                StWaitW: begin
                    wb_o_dat_q <= cw_io_i;
                    wb_cyc_q   <= 1'b1;
                    wb_stb_q   <= 1'b1;
                    cnt_q      <= '0;
                    state_q    <= StWb;
                end
                StWb: begin
                    // wb_err wins over wb_ack; an ack in the final counted cycle still completes
                    if (wb_err || (!wb_ack && timeout)) begin
                        wb_stb_q <= 1'b0;
                        wb_cyc_q <= 1'b0;
                        cw_err_q <= 1'b1;
                        state_q  <= StResp;
                    end else if (wb_ack) begin
                        wb_stb_q <= 1'b0;
                        cw_ack_q <= 1'b1;
                        if (!wb_we_q) begin
                            rdata_q <= wb_i_dat;
                        end
                        if (beat_q == last_q) begin
                            wb_cyc_q <= 1'b0;
                        end
                        state_q <= StResp;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StResp: begin
                    // cw_err_q is high in this state exactly when the beat failed
                    if (cw_err_q || (beat_q == last_q)) begin
                        state_q <= StIdle;
                    end else begin
                        beat_q   <= beat_q + 3'd1;
                        wb_adr_q <= wb_adr_q + WbAddrW'(1);
                        if (wb_we_q) begin
                            state_q <= StWaitW;
                        end else begin
                            wb_stb_q <= 1'b1;
                            cnt_q    <= '0;
                            state_q  <= StWb;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cw_responder.sv
// Directed bench for cw_responder: a wishbone slave model with configurable
// latency/error/mute logs every beat; scenario tasks check against fixed values.
module tb_cw_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cw_io_i = '0;
    logic [15:0] cw_io_o;
    logic        cw_io_oe;
    logic        cw_req = 1'b0;
    logic        cw_dir = 1'b0;
    logic        cw_ack;
    logic        cw_err;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [23:0] wb_adr;
    logic [15:0] wb_o_dat;
    logic [15:0] wb_i_dat;
    logic [1:0]  wb_sel;
    logic        wb_ack;
    logic        wb_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Monitor / slave state
    int          cyc_n = 0;
    int          ack_cnt = 0;
    int          err_cnt = 0;
    int          both_cnt = 0;
    int          cyc_rises = 0;
    int          log_n = 0;
    int          wait_n = 0;
    int          cw_ack_cyc = 0;
    int          cw_err_cyc = 0;
    int          wb_fin_cyc = 0;
    int          stb_rise_cyc = 0;
    logic        err_cyc_lvl = 1'b1;
    logic        cyc_prev = 1'b0;
    logic        stb_prev = 1'b0;
    logic [23:0] log_adr[64];
    logic        log_we[64];
    logic [15:0] log_dat[64];
    logic [1:0]  log_sel[64];
    logic [15:0] rd_log[64];
    int          slv_delay = 0;
    bit          slv_mute = 1'b0;
    int          slv_err_at = -1;
    bit          slv_both = 1'b0;

    logic [15:0] wr_words[8];

    cw_responder #(
        .TIMEOUT(4)
    ) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .cw_io_i (cw_io_i),
        .cw_io_o (cw_io_o),
        .cw_io_oe(cw_io_oe),
        .cw_req  (cw_req),
        .cw_dir  (cw_dir),
        .cw_ack  (cw_ack),
        .cw_err  (cw_err),
        .wb_cyc  (wb_cyc),
        .wb_stb  (wb_stb),
        .wb_we   (wb_we),
        .wb_adr  (wb_adr),
        .wb_o_dat(wb_o_dat),
        .wb_i_dat(wb_i_dat),
        .wb_sel  (wb_sel),
        .wb_ack  (wb_ack),
        .wb_err  (wb_err)
    );

    always #5 clk = ~clk;

    // Monitor then slave, once per cycle on the falling edge
    initial begin
        wb_ack   = 1'b0;
        wb_err   = 1'b0;
        wb_i_dat = '0;
        forever begin
            @(negedge clk);
            cyc_n++;
            if (cw_ack) begin
                if (ack_cnt < 64) rd_log[ack_cnt] = cw_io_o;
                ack_cnt++;
                cw_ack_cyc = cyc_n;
            end
            if (cw_err) begin
                err_cnt++;
                cw_err_cyc  = cyc_n;
                err_cyc_lvl = wb_cyc;
            end
            if (cw_ack && cw_err) both_cnt++;
            if (wb_cyc && !cyc_prev) cyc_rises++;
            cyc_prev = wb_cyc;
            if (wb_stb && !stb_prev) stb_rise_cyc = cyc_n;
            stb_prev = wb_stb;
            wb_ack = 1'b0;
            wb_err = 1'b0;
            if (wb_cyc && wb_stb && !slv_mute) begin
                if (wait_n == slv_delay) begin
                    if (log_n < 64) begin
                        log_adr[log_n] = wb_adr;
                        log_we[log_n]  = wb_we;
                        log_dat[log_n] = wb_o_dat;
                        log_sel[log_n] = wb_sel;
                    end
                    if (log_n == slv_err_at) wb_err = 1'b1;
                    if (log_n != slv_err_at || slv_both) wb_ack = 1'b1;
                    wb_i_dat   = wb_adr[15:0] + 16'h1000;
                    wb_fin_cyc = cyc_n;
                    log_n++;
                    wait_n = 0;
                end else begin
                    wait_n++;
                end
            end else begin
                wait_n = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
        $fatal(1, "watchdog");
    end

    // Header then address word; returns at the falling edge of the cycle after ADR
    task automatic send_header(input logic [15:0] hdr, input logic [15:0] adr, input logic dir);
        @(negedge clk);
        cw_req  = 1'b1;
        cw_io_i = hdr;
        cw_dir  = dir;
        @(negedge clk);
        cw_req  = 1'b0;
        cw_io_i = adr;
        @(negedge clk);
        cw_io_i = '0;
    endtask

    // Run a frame for a fixed window, feeding the next write word after each cw_ack
    task automatic drive_frame(input int max_cyc, output int acks, output int errs);
        int k;
        k    = 0;
        acks = 0;
        errs = 0;
        cw_io_i = wr_words[0];
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (cw_ack) begin
                acks++;
                k++;
                if (k < 8) cw_io_i = wr_words[k];
            end
            if (cw_err) errs++;
        end
        cw_io_i = '0;
    endtask

    task automatic test_reset();
        cw_dir = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({wb_cyc, wb_stb, wb_we, cw_ack, cw_err, cw_io_oe} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b required 000000",
                     {wb_cyc, wb_stb, wb_we, cw_ack, cw_err, cw_io_oe});
        end
        n_cmp++;
        if ({wb_adr, wb_o_dat, cw_io_o, wb_sel} !== 58'h0) begin
            n_bad++;
            $display("FAIL reset_data: adr %h dat %h io %h sel %h required all 0",
                     wb_adr, wb_o_dat, cw_io_o, wb_sel);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        cw_dir = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_write();
        int base, acks, errs;
        slv_delay  = 1;
        base       = log_n;
        wr_words[0] = 16'hBEEF;
        send_header(16'h8012, 16'h3456, 1'b0);
        n_cmp++;
        if ({cw_ack, cw_err, wb_cyc} !== 3'b000) begin
            n_bad++;
            $display("FAIL wr_header_quiet: ack/err/cyc %b required 000", {cw_ack, cw_err, wb_cyc});
        end
        drive_frame(20, acks, errs);
        n_cmp++;
        if (acks !== 1 || errs !== 0) begin
            n_bad++;
            $display("FAIL wr_acks: acks %0d errs %0d required 1 0", acks, errs);
        end
        n_cmp++;
        if (log_n - base !== 1) begin
            n_bad++;
            $display("FAIL wr_beats: got %0d required 1", log_n - base);
        end
        n_cmp++;
        if ({log_adr[base], log_we[base], log_dat[base], log_sel[base]} !== {24'h123456, 1'b1,
            16'hBEEF, 2'd0}) begin
            n_bad++;
            $display("FAIL wr_txn: adr %h we %b dat %h sel %0d required 123456 1 beef 0",
                     log_adr[base], log_we[base], log_dat[base], log_sel[base]);
        end
        n_cmp++;
        if (wb_cyc !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_cyc_end: got %b required 0", wb_cyc);
        end
    endtask

    task automatic test_read_burst4();
        int base, a0, r0, acks, errs;
        logic [23:0] exp_adr[4];
        logic [15:0] exp_dat[4];
        exp_adr = '{24'h12FFFE, 24'h12FFFF, 24'h130000, 24'h130001};
        exp_dat = '{16'h0FFE, 16'h0FFF, 16'h1000, 16'h1001};
        slv_delay = 0;
        base = log_n;
        a0   = ack_cnt;
        r0   = cyc_rises;
        send_header(16'h5812, 16'hFFFE, 1'b1);
        drive_frame(30, acks, errs);
        n_cmp++;
        if (acks !== 4 || errs !== 0 || log_n - base !== 4) begin
            n_bad++;
            $display("FAIL rd4_counts: acks %0d errs %0d beats %0d required 4 0 4",
                     acks, errs, log_n - base);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({log_adr[base+i], log_we[base+i], log_sel[base+i]} !== {exp_adr[i], 1'b0, 2'd3})
            begin
                n_bad++;
                $display("FAIL rd4_txn%0d: adr %h we %b sel %0d required %h 0 3", i,
                         log_adr[base+i], log_we[base+i], log_sel[base+i], exp_adr[i]);
            end
            n_cmp++;
            if (rd_log[a0+i] !== exp_dat[i]) begin
                n_bad++;
                $display("FAIL rd4_data%0d: got %h required %h", i, rd_log[a0+i], exp_dat[i]);
            end
        end
        n_cmp++;
        if (cyc_rises - r0 !== 1) begin
            n_bad++;
            $display("FAIL rd4_cyc_continuous: cyc rises %0d required 1", cyc_rises - r0);
        end
        n_cmp++;
        if (cw_ack_cyc - wb_fin_cyc !== 1) begin
            n_bad++;
            $display("FAIL rd4_latency: got %0d cycles required 1", cw_ack_cyc - wb_fin_cyc);
        end
        n_cmp++;
        if ({cw_io_oe, cw_io_o} !== 17'h0) begin
            n_bad++;
            $display("FAIL rd4_idle_bus: oe %b io %h required 0 0", cw_io_oe, cw_io_o);
        end
        cw_dir = 1'b0;
    endtask

    task automatic test_wrap();
        int base, acks, errs;
        logic [23:0] exp_adr[8];
        exp_adr = '{24'hFFFFFC, 24'hFFFFFD, 24'hFFFFFE, 24'hFFFFFF,
                    24'h000000, 24'h000001, 24'h000002, 24'h000003};
        slv_delay = 1;
        base = log_n;
        send_header(16'h20FF, 16'hFFFC, 1'b0);
        drive_frame(50, acks, errs);
        n_cmp++;
        if (acks !== 8 || errs !== 0 || log_n - base !== 8) begin
            n_bad++;
            $display("FAIL wrap_counts: acks %0d errs %0d beats %0d required 8 0 8",
                     acks, errs, log_n - base);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (log_adr[base+i] !== exp_adr[i]) begin
                n_bad++;
                $display("FAIL wrap_adr%0d: got %h required %h", i, log_adr[base+i], exp_adr[i]);
            end
        end
    endtask

    task automatic test_err_mid_burst();
        int base, acks, errs;
        slv_delay  = 1;
        base       = log_n;
        slv_err_at = base + 1;
        wr_words   = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0, 16'h0, 16'h0, 16'h0};
        send_header(16'hC001, 16'h0010, 1'b0);
        drive_frame(40, acks, errs);
        slv_err_at = -1;
        n_cmp++;
        if (acks !== 1 || errs !== 1) begin
            n_bad++;
            $display("FAIL err_pulses: acks %0d errs %0d required 1 1", acks, errs);
        end
        n_cmp++;
        if (log_n - base !== 2) begin
            n_bad++;
            $display("FAIL err_beats: got %0d required 2", log_n - base);
        end
        n_cmp++;
        if ({log_adr[base+1], log_dat[base+1]} !== {24'h010011, 16'h2222}) begin
            n_bad++;
            $display("FAIL err_beat2: adr %h dat %h required 010011 2222",
                     log_adr[base+1], log_dat[base+1]);
        end
        n_cmp++;
        if (cw_err_cyc - wb_fin_cyc !== 1 || err_cyc_lvl !== 1'b0) begin
            n_bad++;
            $display("FAIL err_timing: delay %0d cyc %b required 1 0",
                     cw_err_cyc - wb_fin_cyc, err_cyc_lvl);
        end
    endtask

    task automatic test_err_priority();
        int base, acks, errs;
        slv_delay  = 0;
        base       = log_n;
        slv_err_at = base;
        slv_both   = 1'b1;
        send_header(16'h0000, 16'h0100, 1'b0);
        drive_frame(15, acks, errs);
        slv_err_at = -1;
        slv_both   = 1'b0;
        n_cmp++;
        if (acks !== 0 || errs !== 1) begin
            n_bad++;
            $display("FAIL err_priority: acks %0d errs %0d required 0 1", acks, errs);
        end
    endtask

    task automatic test_timeout();
        int base, acks, errs;
        slv_mute = 1'b1;
        base     = log_n;
        send_header(16'h0005, 16'h0000, 1'b1);
        drive_frame(20, acks, errs);
        slv_mute = 1'b0;
        n_cmp++;
        if (acks !== 0 || errs !== 1) begin
            n_bad++;
            $display("FAIL to_pulses: acks %0d errs %0d required 0 1", acks, errs);
        end
        n_cmp++;
        if (cw_err_cyc - stb_rise_cyc !== 5) begin
            n_bad++;
            $display("FAIL to_delay: got %0d cycles required 5", cw_err_cyc - stb_rise_cyc);
        end
        n_cmp++;
        if ({wb_cyc, wb_stb, cw_io_oe} !== 3'b000) begin
            n_bad++;
            $display("FAIL to_idle: cyc/stb/oe %b required 000", {wb_cyc, wb_stb, cw_io_oe});
        end
        cw_dir = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        int a0, e0, rises;
        bit hit;
        logic prev;
        slv_delay = 2;
        a0    = ack_cnt;
        e0    = err_cnt;
        rises = 0;
        hit   = 1'b0;
        prev  = 1'b0;
        send_header(16'h200A, 16'h0000, 1'b1);
        for (int c = 0; c < 60 && !hit; c++) begin
            if (wb_stb && !prev) rises++;
            prev = wb_stb;
            if (rises == 3) begin
                hit   = 1'b1;
                rst_n = 1'b0;
                #1;
                n_cmp++;
                if ({wb_cyc, wb_stb, wb_we, cw_ack, cw_err, cw_io_oe} !== 6'b0) begin
                    n_bad++;
                    $display("FAIL rst_mid_ctrl: got %b required 000000",
                             {wb_cyc, wb_stb, wb_we, cw_ack, cw_err, cw_io_oe});
                end
                n_cmp++;
                if ({wb_adr, wb_o_dat, cw_io_o, wb_sel} !== 58'h0) begin
                    n_bad++;
                    $display("FAIL rst_mid_data: adr %h dat %h io %h sel %h required all 0",
                             wb_adr, wb_o_dat, cw_io_o, wb_sel);
                end
            end else begin
                @(negedge clk);
            end
        end
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL rst_mid_reach: beat 3 strobe not seen, required within 60 cycles");
        end
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        cw_dir = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (ack_cnt - a0 !== 2 || err_cnt - e0 !== 0 || wb_cyc !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_after: acks %0d errs %0d cyc %b required 2 0 0",
                     ack_cnt - a0, err_cnt - e0, wb_cyc);
        end
    endtask

    task automatic test_invalid_header();
        int base, e0;
        base = log_n;
        e0   = err_cnt;
        send_header(16'h6000, 16'h1234, 1'b0);
        n_cmp++;
        if ({cw_err, cw_ack, wb_cyc} !== 3'b100) begin
            n_bad++;
            $display("FAIL bad_hdr_err: err/ack/cyc %b required 100", {cw_err, cw_ack, wb_cyc});
        end
        repeat (6) @(negedge clk);
        n_cmp++;
        if (log_n - base !== 0 || err_cnt - e0 !== 1 || wb_cyc !== 1'b0) begin
            n_bad++;
            $display("FAIL bad_hdr_after: beats %0d errs %0d cyc %b required 0 1 0",
                     log_n - base, err_cnt - e0, wb_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_burst4();
        test_wrap();
        test_err_mid_burst();
        test_err_priority();
        test_timeout();
        test_reset_mid_burst();
        test_invalid_header();
        n_cmp++;
        if (both_cnt !== 0) begin
            n_bad++;
            $display("FAIL ack_err_exclusive: overlaps %0d required 0", both_cnt);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cw_responder.md
CW_RESPONDER -- requirements
Module: cw_responder

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: wishbone cycles allowed per beat before the beat is abandoned with an error.
REQ-002 SHALL have ports i_clk, input, 1: single clock for all logic; one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port i_rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have CW bus ports:
- cw_io_i, input, `RW (16): data from the initiator.
- cw_io_o, output, `RW: data to the initiator.
- cw_io_oe, output, 1: cw_io_o drive enable.
- cw_req, input, 1: one-cycle frame-start strobe.
- cw_dir, input, 1: bus direction; 1 = responder drives.
- cw_ack, output, 1: one-cycle beat done.
- cw_err, output, 1: one-cycle beat error.
REQ-005 SHALL have wishbone master ports:
- wb_cyc, wb_stb, wb_we, outputs, 1 each.
- wb_adr, output, `WB_ADDR_W (24).
- wb_o_dat, output, `RW.
- wb_i_dat, input, `RW.
- wb_sel, output, 2.
- wb_ack, wb_err, inputs, 1 each.

Function
REQ-006 SHALL use frame word 0 (cw_req=1) as the header:
- [15] we.
- [14] burst4.
- [13] burst8.
- [12:11] sel.
- [10:8] reserved.
- [7:0] adr[23:16].
REQ-007 SHALL use frame word 1 (the cycle after cw_req) as adr[15:0], with no cw_ack for either header word.
REQ-008 SHALL use states IDLE, ADR, WAIT_W, WB, RESP, with transitions:
- IDLE -> ADR on cw_req.
- ADR -> WAIT_W if we.
- ADR -> WB if read.
- WAIT_W -> WB the next cycle, latching cw_io_i as write data.
- WB -> RESP on wb_ack, wb_err or timeout.
- RESP -> WAIT_W/WB for the next beat, or -> IDLE after the last beat.
REQ-009 SHALL set the beat count to 1, 4 or 8 from burst4/burst8; burst4 and burst8 both set SHALL give cw_err in the ADR+1 cycle, no wishbone cycle, and return to IDLE.
REQ-010 SHALL drive wb_adr = base + beat index, modulo 2^24, so the address wraps at 24'hFFFFFF.
REQ-011 SHALL hold wb_cyc from the first beat's WB entry until the last beat's RESP; wb_stb SHALL be high only in WB; wb_we and wb_sel SHALL be constant for the frame.
REQ-012 SHALL, on a read beat, register wb_i_dat on wb_ack and present it on cw_io_o during RESP together with cw_ack=1 (exactly one cycle).
REQ-013 SHALL, on a write beat, assert cw_ack in RESP after wb_ack; the initiator presents the next write word in the cycle after cw_ack.
REQ-014 SHALL have latency (read, single beat) from wb_ack in cycle n to cw_ack in cycle n+1.
REQ-015 SHALL, on wb_err or timeout, pulse cw_err (not cw_ack) in RESP, drop wb_cyc, abort remaining beats and go to IDLE.
REQ-016 SHALL count the timeout in an 8-bit+ counter cleared on WB entry; timeout fires when the count reaches TIMEOUT while neither wb_ack nor wb_err is seen.
REQ-017 SHALL give wb_err priority over wb_ack when both arrive in the same cycle.
REQ-018 SHALL ignore cw_req outside IDLE, with no state change.
REQ-019 SHALL set cw_io_oe = cw_dir & (state != IDLE); cw_io_o SHALL be 0 whenever cw_io_oe=0.
REQ-020 SHALL never assert cw_ack and cw_err in the same cycle.

Reset
REQ-021 SHALL on i_rst_n=0 immediately force: state IDLE; wb_cyc, wb_stb, wb_we, cw_ack, cw_err, cw_io_oe = 0; wb_adr, wb_o_dat, cw_io_o, wb_sel = 0; counters = 0.
REQ-022 SHALL, on reset asserted mid-burst, drop wb_cyc immediately, emit no cw_ack/cw_err, and after release accept only a fresh cw_req.

Structure
REQ-023 SHALL take `RW, `WB_ADDR_W and the header bit-position constants from the shared config.v include; the CW compressor SHALL use the same constants.
REQ-024 SHALL be a single module with no sub-modules; the timeout counter stays inline.

Verification
REQ-025 SHALL cover single write: header 16'h8012 (we, sel=0, adr hi 12), adr 16'h3456, data 16'hBEEF -> one WB write to 24'h123456, dat BEEF, sel 0; one cw_ack.
REQ-026 SHALL cover read burst4: header 16'h5812 (burst4, sel=3), adr 16'hFFFE, cw_dir=1 -> reads at 12FFFE, 12FFFF, 130000, 130001; four cw_ack with the returned data; wb_cyc continuous.
REQ-027 SHALL cover address wrap: burst8 read at 24'hFFFFFC -> beats 5-8 addressed 000000..000003.
REQ-028 SHALL cover error mid-burst: write burst4 with wb_err on beat 2 -> cw_ack on beat 1, cw_err on beat 2, wb_cyc low next cycle, no beats 3-4.
REQ-029 SHALL cover timeout: slave never acks, TIMEOUT=4 -> cw_err 5 cycles after wb_stb rises; then IDLE.
REQ-030 SHALL cover reset and invalid header: i_rst_n low during beat 3 of an 8-read -> all outputs 0 asynchronously; header 16'h6000 -> cw_err, no wb_cyc.
